// File: rtl/decision_wait_sched.sv
// Round-robin scheduler sharing one two-way decision-wait element between two
// synchronous requesters, using two-phase arm/fire signalling and synchronised z returns.
module decision_wait_sched #(
  parameter int SYNC_STAGES = 2,
  parameter int TO_W        = 8,
  parameter int TO_CYCLES   = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] done,
  output logic       busy,
  output logic       a1_o,
  output logic       a2_o,
  output logic       fire_o,
  input  logic       z1_i,
  input  logic       z2_i,
  output logic       err,
  input  logic       clr_err
);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, WAIT_Z, DONE, ERR} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] z1_sync;
  logic [SYNC_STAGES-1:0] z2_sync;
  logic                   z1s;
  logic                   z2s;
  logic                   ez1;
  logic                   ez2;
  logic                   rr;
  logic                   sel;
  logic [TO_W-1:0]        wd;
  logic                   pick;
  logic                   pick_valid;
  logic                   complete;
  logic                   timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z1_sync <= '0;
      z2_sync <= '0;
    end else begin
      z1_sync <= {z1_sync[SYNC_STAGES-2:0], z1_i};
      z2_sync <= {z2_sync[SYNC_STAGES-2:0], z2_i};
    end
  end

  assign z1s = z1_sync[SYNC_STAGES-1];
  assign z2s = z2_sync[SYNC_STAGES-1];

  // Only the selected channel can complete; a stray edge on the other one stays pending.
  assign complete = sel ? (z2s != ez2) : (z1s != ez1);
  assign timeout  = (wd == TO_W'(TO_CYCLES - 1));

  always_comb begin
    pick_valid = 1'b0;
    pick       = rr;
    if (req[rr]) begin
      pick_valid = 1'b1;
      pick       = rr;
    end else if (req[~rr]) begin
      pick_valid = 1'b1;
      pick       = ~rr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 2'b00;
      busy   <= 1'b0;
      a1_o   <= 1'b0;
      a2_o   <= 1'b0;
      fire_o <= 1'b0;
      err    <= 1'b0;
      ez1    <= 1'b0;
      ez2    <= 1'b0;
      rr     <= 1'b0;
      sel    <= 1'b0;
      wd     <= '0;
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sel   <= pick;
            busy  <= 1'b1;
            state <= ARM;
          end
        end
        ARM: begin
          if (sel) a2_o <= ~a2_o;
          else     a1_o <= ~a1_o;
          state <= FIRE;
        end
        FIRE: begin
          fire_o <= ~fire_o;
          wd     <= '0;
          state  <= WAIT_Z;
        end
        WAIT_Z: begin
          if (complete) begin
            if (sel) ez2 <= ~ez2;
            else     ez1 <= ~ez1;
            rr    <= ~sel;
            done  <= sel ? 2'b10 : 2'b01;
            state <= DONE;
          end else if (timeout) begin
            err   <= 1'b1;
            state <= ERR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          if (clr_err) begin
            // Adopt whatever phase the element is showing now so both channels realign.
            err   <= 1'b0;
            ez1   <= z1s;
            ez2   <= z2s;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decision_wait_sched.sv
// Directed bench for decision_wait_sched; the bench plays both requesters and the element.
module tb_decision_wait_sched;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] done;
  logic       busy;
  logic       a1_o;
  logic       a2_o;
  logic       fire_o;
  logic       z1_i;
  logic       z2_i;
  logic       err;
  logic       clr_err;

  int n_checks;
  int n_fail;
  logic count_en;
  logic prev_a1, prev_a2, prev_fire;
  int cnt_a1, cnt_a2, cnt_fire;

  decision_wait_sched #(.SYNC_STAGES(2), .TO_W(8), .TO_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .busy(busy),
    .a1_o(a1_o), .a2_o(a2_o), .fire_o(fire_o),
    .z1_i(z1_i), .z2_i(z2_i), .err(err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!count_en) begin
      cnt_a1 = 0; cnt_a2 = 0; cnt_fire = 0;
    end else begin
      if (a1_o !== prev_a1) cnt_a1++;
      if (a2_o !== prev_a2) cnt_a2++;
      if (fire_o !== prev_fire) cnt_fire++;
    end
    prev_a1 = a1_o; prev_a2 = a2_o; prev_fire = fire_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fire(input string tag);
    logic f0;
    int n;
    f0 = fire_o;
    n = 0;
    while (fire_o === f0 && n < 10) begin
      tick();
      n++;
    end
    check(tag, {31'd0, fire_o !== f0}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (done === 2'b00 && n < 30);
    check(tag, {30'd0, done}, {30'd0, exp});
  endtask

  // Element model: respond on the expected channel after `delay` cycles past fire.
  task automatic run_txn(input string tag, input logic [1:0] exp, input int delay);
    wait_fire({tag, "_fire"});
    repeat (delay) tick();
    if (exp == 2'b01) z1_i = ~z1_i;
    else              z2_i = ~z2_i;
    wait_done({tag, "_done"}, exp);
  endtask

  initial begin
    logic saw_done;
    logic f_hold, a2_hold;
    clk = 0; rst = 1; req = 2'b00; z1_i = 0; z2_i = 0; clr_err = 0;
    n_checks = 0; n_fail = 0; count_en = 0;

    // Reset state
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outs", {26'd0, done, a1_o, a2_o, fire_o, err}, 32'd0);
    rst = 0;
    tick();

    // Single transaction, element responds 2 cycles after the fire edge
    req = 2'b01;
    tick();
    check("t1_busy_c1", {31'd0, busy}, 32'd1);
    check("t1_a1_c1", {31'd0, a1_o}, 32'd0);
    tick();
    check("t1_a1_c2", {31'd0, a1_o}, 32'd1);
    check("t1_fire_c2", {31'd0, fire_o}, 32'd0);
    tick();
    check("t1_fire_c3", {31'd0, fire_o}, 32'd1);
    repeat (2) tick();
    z1_i = 1;
    tick(); tick();
    check("t1_done_early", {30'd0, done}, 32'd0);
    tick();
    check("t1_done", {30'd0, done}, 32'd1);
    check("t1_busy_done", {31'd0, busy}, 32'd1);
    req = 2'b00;
    tick();
    check("t1_done_pulse", {30'd0, done}, 32'd0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    check("t1_a2", {31'd0, a2_o}, 32'd0);

    // Serve requester 1 once so the pointer returns to requester 0
    req = 2'b10;
    run_txn("pre_rr", 2'b10, 1);
    req = 2'b00;
    tick(); tick();

    // Continuous contention alternates grants
    count_en = 1;
    tick();
    req = 2'b11;
    run_txn("rr_0", 2'b01, 1);
    run_txn("rr_1", 2'b10, 0);
    run_txn("rr_2", 2'b01, 3);
    run_txn("rr_3", 2'b10, 1);
    req = 2'b00;
    repeat (3) tick();
    check("rr_a1_toggles", cnt_a1, 32'd2);
    check("rr_a2_toggles", cnt_a2, 32'd2);
    check("rr_fire_toggles", cnt_fire, 32'd4);
    count_en = 0;

    // Element never answers: watchdog fires exactly 200 cycles into WAIT_Z
    req = 2'b01;
    wait_fire("to_fire");
    saw_done = 0;
    for (int i = 0; i < 199; i++) begin
      tick();
      if (done !== 2'b00) saw_done = 1;
    end
    check("to_err_early", {31'd0, err}, 32'd0);
    tick();
    check("to_err", {31'd0, err}, 32'd1);
    check("to_no_done", {31'd0, saw_done | (done !== 2'b00)}, 32'd0);
    req = 2'b10;
    f_hold = fire_o; a2_hold = a2_o;
    repeat (6) tick();
    check("to_req_ignored", {30'd0, fire_o, a2_o}, {30'd0, f_hold, a2_hold});
    check("to_err_sticky", {31'd0, err}, 32'd1);
    req = 2'b00;
    clr_err = 1;
    tick();
    clr_err = 0;
    check("clr_err", {31'd0, err}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    req = 2'b10;
    run_txn("clr_next", 2'b10, 2);
    req = 2'b00;
    tick(); tick();

    // Completion lands on the same cycle as the timeout: completion wins
    req = 2'b01;
    wait_fire("edge_fire");
    repeat (197) tick();
    z1_i = ~z1_i;
    tick(); tick();
    check("edge_before", {29'd0, err, done}, 32'd0);
    tick();
    check("edge_done", {30'd0, done}, 32'd1);
    check("edge_no_err", {31'd0, err}, 32'd0);
    req = 2'b00;
    tick(); tick();

    // Reset asserted while waiting for the element
    req = 2'b01;
    wait_fire("rst_fire");
    tick(); tick();
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1;
    z1_i = 0; z2_i = 0;
    req = 2'b00;
    #1;
    check("rst_mid_outs", {25'd0, busy, done, a1_o, a2_o, fire_o, err}, 32'd0);
    tick();
    rst = 0;
    tick();
    check("rst_idle", {31'd0, busy}, 32'd0);
    req = 2'b10;
    run_txn("rst_sel1", 2'b10, 1);
    req = 2'b11;
    run_txn("rst_rr0", 2'b01, 1);
    req = 2'b00;
    tick(); tick();

    // Stray z2 edge while serving requester 0 shows up as instant completion for requester 1
    req = 2'b01;
    wait_fire("spur_fire");
    tick();
    z2_i = ~z2_i;
    tick();
    z1_i = ~z1_i;
    wait_done("spur_txn0", 2'b01);
    req = 2'b00;
    tick(); tick();
    req = 2'b10;
    wait_fire("spur_fire1");
    tick();
    check("spur_instant_done1", {30'd0, done}, 32'd2);
    req = 2'b00;
    tick(); tick();
    check("spur_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
